// File: rtl/crc_chk_rr_arbiter.sv
// Frame-atomic round-robin arbiter sharing one CRC data-check pipeline among NUM_PORTS readers.
// Optional per-port error counters (oErrCnt, iCntClr) are built when CRC_CHK_ERR_CNT_EN is defined.
module crc_chk_rr_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int PID_W       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic [NUM_PORTS-1:0]        iReq,
  input  logic [NUM_PORTS-1:0]        iSop,
  input  logic [NUM_PORTS-1:0]        iEop,
  input  logic [NUM_PORTS-1:0]        iVld,
  input  logic [NUM_PORTS-1:0]        iLast,
  input  logic [NUM_PORTS*DATA_W-1:0] iData,
  output logic [NUM_PORTS-1:0]        oAck,
  output logic [NUM_PORTS-1:0]        oGrant,
  output logic                        oChkSop,
  output logic                        oChkEop,
  output logic                        oChkVld,
  output logic                        oChkLast,
  output logic [DATA_W-1:0]           oChkData,
  input  logic                        iChkReady,
  input  logic                        iChkEop,
  input  logic                        iChkErr,
  output logic                        oResVld,
  output logic [PID_W-1:0]            oResPort,
  output logic                        oResErr,
  output logic                        oResTo,
  output logic                        oBusy
`ifdef CRC_CHK_ERR_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]     oErrCnt,
  input  logic                        iCntClr
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]           state;
  logic [NUM_PORTS-1:0] grant;
  logic [PID_W-1:0]     grant_id;
  logic [PID_W-1:0]     ptr;
  logic [CNT_W-1:0]     cnt;
  logic                 res_vld;
  logic                 res_err;
  logic                 res_to;
  logic [PID_W-1:0]     res_port;

  logic                 sel_found;
  logic [PID_W-1:0]     sel_id;
  logic                 last_acc;
  logic [DATA_W-1:0]    chk_data;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!sel_found && iReq[idx]) begin
        sel_found = 1'b1;
        sel_id    = PID_W'(idx);
      end
    end
  end

  // grant is all-zero outside XFER, so masking by it also gates the checker side.
  always_comb begin
    chk_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) chk_data = chk_data | iData[k*DATA_W +: DATA_W];
    end
  end

  assign oChkData = chk_data;
  assign oChkSop  = |(iSop  & grant);
  assign oChkEop  = |(iEop  & grant);
  assign oChkVld  = |(iVld  & grant);
  assign oChkLast = |(iLast & grant);
  assign oAck     = grant & {NUM_PORTS{iChkReady}};
  assign oGrant   = grant;
  assign oBusy    = (state != S_IDLE);
  assign oResVld  = res_vld;
  assign oResPort = res_port;
  assign oResErr  = res_err;
  assign oResTo   = res_to;

  assign last_acc = oChkVld & oChkLast & iChkReady;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= PID_W'(NUM_PORTS - 1);
      cnt      <= '0;
      res_vld  <= 1'b0;
      res_err  <= 1'b0;
      res_to   <= 1'b0;
      res_port <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            grant    <= NUM_PORTS'(1) << sel_id;
            grant_id <= sel_id;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (last_acc) begin
            grant <= '0;
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A verdict on the expiry cycle beats the timeout.
          if (iChkEop) begin
            res_vld  <= 1'b1;
            res_err  <= iChkErr;
            res_to   <= 1'b0;
            res_port <= grant_id;
            state    <= S_RESULT;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            res_vld  <= 1'b1;
            res_err  <= 1'b1;
            res_to   <= 1'b1;
            res_port <= grant_id;
            state    <= S_RESULT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESULT: begin
          res_vld  <= 1'b0;
          res_err  <= 1'b0;
          res_to   <= 1'b0;
          res_port <= '0;
          ptr      <= grant_id;
          cnt      <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CRC_CHK_ERR_CNT_EN
  logic [NUM_PORTS-1:0][15:0] err_cnt;

  // Saturating per-port error counters; clear wins over a same-cycle increment.
  always_ff @(posedge iClk) begin
    if (iRst || iCntClr) begin
      err_cnt <= '0;
    end else if (res_vld && res_err) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (res_port == PID_W'(k) && err_cnt[k] != 16'hFFFF) begin
          err_cnt[k] <= err_cnt[k] + 16'd1;
        end
      end
    end
  end

  assign oErrCnt = err_cnt;
`endif

endmodule
